instruction_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 35 +++
 rtl/instruction_fetch_unit_if.sv | 20 ++
 rtl/fetch_wait_timer.sv | 49 ++++
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, address-register-file control codes and the wait-counter width.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_LO = 3'd1,
    ST_INC_LO = 3'd2,
    ST_REQ_HI = 3'd3,
    ST_INC_HI = 3'd4,
    ST_DONE   = 3'd5
  } fetch_state_e;

  // Address register file function select
  localparam logic [2:0] FUN_HOLD    = 3'b000;
  localparam logic [2:0] FUN_INC     = 3'b001;

  // Active-low per-register enables: bit2 PC, bit1 AR, bit0 SP
  localparam logic [2:0] REGSEL_NONE = 3'b111;
  localparam logic [2:0] REGSEL_PC   = 3'b011;

  // D-port source select
  localparam logic [1:0] OUTD_PC     = 2'b00;

  localparam int unsigned WAIT_W     = 8;

  function automatic logic is_req_state(input fetch_state_e s);
    return (s == ST_REQ_LO) || (s == ST_REQ_HI);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Byte-wide program memory read handshake.
//   MemReq   : read request (master -> memory)
//   MemAddr  : 16-bit byte address (master -> memory)
//   MemRdata : read data, valid while MemAck=1 (memory -> master)
//   MemAck   : acknowledge, one cycle per request (memory -> master)
// Modports: master (fetch unit), slave (memory).
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;

  logic        MemReq;
  logic [15:0] MemAddr;
  logic [7:0]  MemRdata;
  logic        MemAck;

  modport master (output MemReq, output MemAddr, input MemRdata, input MemAck);
  modport slave  (input MemReq, input MemAddr, output MemRdata, output MemAck);

endinterface

// File: rtl/fetch_wait_timer.sv
// ---------------------------------------------------------------------------
// fetch_wait_timer
// 8-bit wait counter for a pending memory request.
//   Clock         : system clock, rising edge
//   Reset         : synchronous, active-low
//   clr           : clear the count (has priority over en)
//   en            : count one wait cycle
//   limit_reached : count equals WAIT_LIMIT-1 (last permitted wait cycle)
// ---------------------------------------------------------------------------
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic limit_reached
);

  localparam logic [WAIT_W-1:0] LAST_COUNT = WAIT_W'(WAIT_LIMIT - 1);

  logic [WAIT_W-1:0] count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_reached = (count_q == LAST_COUNT);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetches one 16-bit instruction as two little-endian byte reads from
// program memory, addressed by the PC on the address register file's D port,
// incrementing the PC after each accepted byte.
//   Clock, Reset : system clock; synchronous active-low reset
//   Start        : begin a fetch (sampled only in IDLE)
//   Flush        : abort any fetch in progress
//   Address      : PC from the address register file D output
//   mem          : memory read handshake (master side)
//   ARF_FunSel   : register function select (FUN_INC during INC states)
//   ARF_RegSel   : active-low register enables (REGSEL_PC during INC states)
//   ARF_OutDSel  : D-port source, always the PC
//   IR           : assembled instruction, held between fetches
//   IRValid      : one-cycle pulse once both bytes are in IR
//   Busy         : FSM not in IDLE
//   FetchErr     : one-cycle pulse after a request times out
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Start,
  input  logic                            Flush,
  input  logic [15:0]                     Address,
  instruction_fetch_unit_if.master        mem,
  output logic [2:0]                      ARF_FunSel,
  output logic [2:0]                      ARF_RegSel,
  output logic [1:0]                      ARF_OutDSel,
  output logic [15:0]                     IR,
  output logic                            IRValid,
  output logic                            Busy,
  output logic                            FetchErr
);

  fetch_state_e state_q, state_d;
  logic [15:0]  ir_q, ir_d;
  logic         fetch_err_q, fetch_err_d;

  logic in_req;
  logic limit_reached;
  logic timeout;

  assign in_req  = is_req_state(state_q);
  // Last permitted wait cycle passed without an acknowledge.
  assign timeout = in_req && !mem.MemAck && limit_reached;

  // Counter is held clear outside REQ states, so it starts from zero on
  // entry to each REQ state (INC_LO always precedes REQ_HI).
  fetch_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .Clock         (Clock),
    .Reset         (Reset),
    .clr           (!in_req),
    .en            (in_req && !mem.MemAck),
    .limit_reached (limit_reached)
  );

  // State register, IR and error pulse.
  // NOTE: IR is a plain register and is reset with the FSM; it is not a
  // memory array, so resetting it costs nothing special.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state logic. Flush overrides everything, including an acknowledge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (Start) state_d = ST_REQ_LO;
      ST_REQ_LO: begin
        if (mem.MemAck)   state_d = ST_INC_LO;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_INC_LO: state_d = ST_REQ_HI;
      ST_REQ_HI: begin
        if (mem.MemAck)   state_d = ST_INC_HI;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_INC_HI: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (Flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Byte capture happens on the acknowledge even when Flush is asserted.
  always_comb begin
    ir_d = ir_q;
    if (in_req && mem.MemAck) begin
      if (state_q == ST_REQ_LO) ir_d[7:0]  = mem.MemRdata;
      else                      ir_d[15:8] = mem.MemRdata;
    end
  end

  // A flush in the same cycle takes precedence and is not reported as an error.
  assign fetch_err_d = timeout && !Flush;

  // Output decode: purely a function of the current state.
  always_comb begin
    mem.MemReq  = 1'b0;
    mem.MemAddr = 16'h0000;
    ARF_FunSel  = FUN_HOLD;
    ARF_RegSel  = REGSEL_NONE;
    IRValid     = 1'b0;
    unique case (state_q)
      ST_REQ_LO, ST_REQ_HI: begin
        mem.MemReq  = 1'b1;
        mem.MemAddr = Address;
      end
      ST_INC_LO, ST_INC_HI: begin
        ARF_FunSel = FUN_INC;
        ARF_RegSel = REGSEL_PC;
      end
      ST_DONE: IRValid = 1'b1;
      default: ;
    endcase
  end

  assign ARF_OutDSel = OUTD_PC;
  assign IR          = ir_q;
  assign Busy        = (state_q != ST_IDLE);
  assign FetchErr    = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench: a byte memory responder with programmable ack delay, a PC
// model standing in for the address register file, and hand-computed
// expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned WAIT_LIMIT = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic [1:0]  ARF_OutDSel;
  logic [15:0] IR;
  logic        IRValid, Busy, FetchErr;

  // Address register file stand-in: PC loadable by the bench, incremented
  // when the DUT selects PC with FUN_INC.
  logic [15:0] pc          = 16'h0000;
  logic        pc_load     = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;

  logic [7:0]  mem [0:255];
  int          ack_delay = 0;
  logic        stray_ack = 1'b0;
  int          wait_ctr  = 0;

  logic [15:0] addr_log [$];
  int          inc_cnt   = 0;
  int          valid_cnt = 0;
  int          err_cnt   = 0;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit_if mem_bus ();

  instruction_fetch_unit #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Flush       (Flush),
    .Address     (pc),
    .mem         (mem_bus),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_RegSel  (ARF_RegSel),
    .ARF_OutDSel (ARF_OutDSel),
    .IR          (IR),
    .IRValid     (IRValid),
    .Busy        (Busy),
    .FetchErr    (FetchErr)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (pc_load) pc <= pc_load_val;
    else if (ARF_RegSel == 3'b011 && ARF_FunSel == 3'b001) pc <= pc + 16'd1;
  end

  // Memory responder: acks after ack_delay wait cycles; optional stray ack
  // while no request is pending.
  always @(negedge Clock) begin
    if (mem_bus.MemReq) begin
      if (wait_ctr >= ack_delay) begin
        mem_bus.MemAck   = 1'b1;
        mem_bus.MemRdata = mem[mem_bus.MemAddr[7:0]];
        wait_ctr         = 0;
      end else begin
        mem_bus.MemAck   = 1'b0;
        mem_bus.MemRdata = 8'h00;
        wait_ctr         = wait_ctr + 1;
      end
    end else begin
      wait_ctr         = 0;
      mem_bus.MemAck   = stray_ack;
      mem_bus.MemRdata = stray_ack ? 8'hFF : 8'h00;
    end
  end

  // Activity monitor.
  always @(negedge Clock) begin
    if (mem_bus.MemReq) addr_log.push_back(mem_bus.MemAddr);
    if (ARF_RegSel == 3'b011 && ARF_FunSel == 3'b001) inc_cnt = inc_cnt + 1;
    if (IRValid) valid_cnt = valid_cnt + 1;
    if (FetchErr) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic set_pc(input logic [15:0] v);
    @(negedge Clock);
    pc_load_val = v;
    pc_load     = 1'b1;
    @(posedge Clock);
    #1 pc_load = 1'b0;
  endtask

  // Start sampled at edge 0; cycle c is the interval after edge c-1.
  task automatic do_fetch(output int valid_cycle, output int err_cycle, output int idle_cycle);
    valid_cycle = -1;
    err_cycle   = -1;
    idle_cycle  = -1;
    @(negedge Clock);
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      if (IRValid && valid_cycle < 0) valid_cycle = c;
      if (FetchErr && err_cycle < 0) err_cycle = c;
      if (!Busy) begin
        idle_cycle = c;
        break;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ir"},      32'(IR),          32'h0);
    check({pfx, "_irvalid"}, 32'(IRValid),     32'h0);
    check({pfx, "_fetcherr"},32'(FetchErr),    32'h0);
    check({pfx, "_memreq"},  32'(mem_bus.MemReq), 32'h0);
    check({pfx, "_memaddr"}, 32'(mem_bus.MemAddr), 32'h0);
    check({pfx, "_regsel"},  32'(ARF_RegSel),  32'h7);
    check({pfx, "_funsel"},  32'(ARF_FunSel),  32'h0);
    check({pfx, "_outdsel"}, 32'(ARF_OutDSel), 32'h0);
    check({pfx, "_busy"},    32'(Busy),        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, ec, ic;
    int base_inc, base_addr, base_valid, base_err, bad;
    int vcyc [$];
    logic [15:0] virs [$];

    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h40] = 8'hA5; mem[8'h41] = 8'h3C;
    mem[8'h80] = 8'h12; mem[8'h81] = 8'hEF;
    mem[8'h10] = 8'h5A; mem[8'h11] = 8'h77;
    mem[8'h30] = 8'h01; mem[8'h31] = 8'h02; mem[8'h32] = 8'h03;
    mem[8'h50] = 8'h11; mem[8'h51] = 8'h22; mem[8'h52] = 8'h33; mem[8'h53] = 8'h44;

    // ---- Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_reset_outputs("reset");
    Reset = 1'b1;

    // ---- Zero-wait fetch
    set_pc(16'h0040);
    ack_delay = 0;
    base_inc = inc_cnt; base_addr = addr_log.size(); base_valid = valid_cnt;
    do_fetch(vc, ec, ic);
    check("zw_valid_cycle", 32'(vc), 32'd5);
    check("zw_idle_cycle",  32'(ic), 32'd6);
    check("zw_ir",          32'(IR), 32'h3CA5);
    check("zw_pc",          32'(pc), 32'h0042);
    check("zw_inc_pulses",  32'(inc_cnt - base_inc), 32'd2);
    check("zw_valid_pulses",32'(valid_cnt - base_valid), 32'd1);
    check("zw_addr_count",  32'(addr_log.size() - base_addr), 32'd2);
    check("zw_addr_lo", 32'((addr_log.size() > base_addr) ? addr_log[base_addr] : 16'hDEAD), 32'h0040);
    check("zw_addr_hi", 32'((addr_log.size() > base_addr + 1) ? addr_log[base_addr + 1] : 16'hDEAD), 32'h0041);
    repeat (3) @(posedge Clock);
    #1 check("zw_ir_hold", 32'(IR), 32'h3CA5);

    // ---- Three wait cycles on each byte
    set_pc(16'h0080);
    ack_delay = 3;
    base_inc = inc_cnt; base_addr = addr_log.size();
    do_fetch(vc, ec, ic);
    check("ws_valid_cycle", 32'(vc), 32'd11);
    check("ws_ir",          32'(IR), 32'hEF12);
    check("ws_pc",          32'(pc), 32'h0082);
    check("ws_inc_pulses",  32'(inc_cnt - base_inc), 32'd2);
    check("ws_addr_count",  32'(addr_log.size() - base_addr), 32'd8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (base_addr + i < addr_log.size()) begin
        if (addr_log[base_addr + i] !== ((i < 4) ? 16'h0080 : 16'h0081)) bad = bad + 1;
      end
    end
    check("ws_addr_stable", 32'(bad), 32'd0);

    // ---- Timeout: no acknowledge, WAIT_LIMIT=4
    set_pc(16'h0020);
    ack_delay = 255;
    base_inc = inc_cnt; base_addr = addr_log.size(); base_valid = valid_cnt; base_err = err_cnt;
    do_fetch(vc, ec, ic);
    check("to_req_cycles",  32'(addr_log.size() - base_addr), 32'd4);
    check("to_err_cycle",   32'(ec), 32'd5);
    check("to_idle_cycle",  32'(ic), 32'd5);
    check("to_no_valid",    32'(valid_cnt - base_valid), 32'd0);
    check("to_pc",          32'(pc), 32'h0020);
    check("to_inc_pulses",  32'(inc_cnt - base_inc), 32'd0);
    check("to_ir_kept",     32'(IR), 32'hEF12);
    check("to_err_pulses",  32'(err_cnt - base_err), 32'd1);
    check("to_err_low",     32'(FetchErr), 32'd0);

    // ---- Flush during INC_LO
    set_pc(16'h0010);
    ack_delay = 0;
    base_valid = valid_cnt;
    @(negedge Clock);
    Start = 1'b1;
    @(posedge Clock);      // edge 0
    #1 Start = 1'b0;       // cycle 1: REQ_LO
    @(posedge Clock);
    #1 Flush = 1'b1;       // cycle 2: INC_LO
    @(negedge Clock);
    check("fl_in_inc", 32'(ARF_RegSel), 32'h3);
    @(posedge Clock);
    #1 Flush = 1'b0;       // cycle 3
    @(negedge Clock);
    check("fl_busy", 32'(Busy), 32'd0);
    check("fl_pc",   32'(pc),   32'h0011);
    check("fl_ir",   32'(IR),   32'hEF5A);
    repeat (4) @(negedge Clock);
    check("fl_no_valid", 32'(valid_cnt - base_valid), 32'd0);
    check("fl_pc_hold",  32'(pc), 32'h0011);

    // ---- Reset in REQ_HI, then a clean fetch
    set_pc(16'h0030);
    @(negedge Clock);
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;       // cycle 1: REQ_LO
    @(posedge Clock);      // cycle 2: INC_LO
    @(posedge Clock);
    #1 Reset = 1'b0;       // cycle 3: REQ_HI
    @(negedge Clock);
    check("rst_in_req_hi", 32'(mem_bus.MemAddr), 32'h0031);
    @(negedge Clock);      // cycle 4
    check_reset_outputs("rst_mid");
    Reset = 1'b1;
    base_valid = valid_cnt;
    do_fetch(vc, ec, ic);
    check("rst_refetch_valid", 32'(vc), 32'd5);
    check("rst_refetch_ir",    32'(IR), 32'h0302);
    check("rst_refetch_pc",    32'(pc), 32'h0033);

    // ---- Start held high, stray acknowledges outside REQ
    set_pc(16'h0050);
    stray_ack  = 1'b1;
    base_valid = valid_cnt;
    @(negedge Clock);
    Start = 1'b1;
    @(posedge Clock);      // edge 0
    for (int c = 1; c <= 11; c++) begin
      @(negedge Clock);
      if (IRValid) begin
        vcyc.push_back(c);
        virs.push_back(IR);
      end
      if (c == 11) Start = 1'b0;
    end
    repeat (4) @(negedge Clock);
    check("b2b_valid_count", 32'(vcyc.size()), 32'd2);
    check("b2b_valid0_cycle", 32'((vcyc.size() > 0) ? vcyc[0] : -1), 32'd5);
    check("b2b_valid1_cycle", 32'((vcyc.size() > 1) ? vcyc[1] : -1), 32'd11);
    check("b2b_ir0", 32'((virs.size() > 0) ? virs[0] : 16'hDEAD), 32'h2211);
    check("b2b_ir1", 32'((virs.size() > 1) ? virs[1] : 16'hDEAD), 32'h4433);
    check("b2b_idle_busy", 32'(Busy), 32'd0);
    check("b2b_ir_kept",   32'(IR),   32'h4433);
    check("b2b_pc",        32'(pc),   32'h0054);
    check("b2b_total_valid", 32'(valid_cnt - base_valid), 32'd2);
    stray_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
